// File: rtl/note_sequence_player_if.sv
// Play controls in, tone selection and song status out, between the top-level
// controls, the melody sequencer and the PWM tone generator.
interface note_sequence_player_if;
  logic       play;
  logic       restart;
  logic       loop_en;
  logic [3:0] note_select;
  logic       note_gate;
  logic       step_strobe;
  logic [3:0] song_pos;
  logic       done;

  modport master (
    output play, restart, loop_en,
    input  note_select, note_gate, step_strobe, song_pos, done
  );

  modport slave (
    input  play, restart, loop_en,
    output note_select, note_gate, step_strobe, song_pos, done
  );
endinterface

// File: rtl/note_sequence_player.sv
// Melody sequencer: walks a 16-entry {note, length} song ROM on a tempo tick and
// drives note_select/note_gate of the PWM tone generator.
//
// state | meaning
// IDLE  | stopped, gate low, waiting for play
// LOAD  | one cycle: fetch ROM[song_pos], present it on the next edge
// PLAY  | counting tempo ticks for the current entry
// DONE  | song ended without looping; only restart or reset leaves
module note_sequence_player #(
  parameter int unsigned TICK_DIV = 1_573_437,
  parameter int unsigned SONG_LEN = 16,
  parameter logic [3:0]  REST     = 4'hF
) (
  input  logic                   clk,
  input  logic                   reset,
  note_sequence_player_if.slave  bus
);
  localparam int unsigned       DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [3:0]        POS_LAST = 4'(SONG_LEN - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PLAY, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [3:0]       rem_q, rem_d;
  logic [3:0]       pos_q, pos_d;
  logic [3:0]       note_q, note_d;
  logic             gate_q, gate_d;
  logic             strobe_q, strobe_d;
  logic             done_q, done_d;
  logic [3:0]       rom_note, rom_len;
  logic             is_rest, tick, entry_end, is_last;

  always_comb begin
    case (pos_q)
      4'd0:    {rom_note, rom_len} = {4'h0, 4'd2};
      4'd1:    {rom_note, rom_len} = {4'h1, 4'd2};
      4'd2:    {rom_note, rom_len} = {4'h2, 4'd2};
      4'd3:    {rom_note, rom_len} = {4'h3, 4'd4};
      4'd4:    {rom_note, rom_len} = {4'hF, 4'd2};
      4'd5:    {rom_note, rom_len} = {4'h3, 4'd2};
      4'd6:    {rom_note, rom_len} = {4'h4, 4'd2};
      4'd7:    {rom_note, rom_len} = {4'h5, 4'd4};
      4'd8:    {rom_note, rom_len} = {4'h6, 4'd2};
      4'd9:    {rom_note, rom_len} = {4'h7, 4'd2};
      4'd10:   {rom_note, rom_len} = {4'h8, 4'd4};
      4'd11:   {rom_note, rom_len} = {4'hF, 4'd4};
      4'd12:   {rom_note, rom_len} = {4'h8, 4'd2};
      4'd13:   {rom_note, rom_len} = {4'h6, 4'd2};
      4'd14:   {rom_note, rom_len} = {4'h3, 4'd2};
      default: {rom_note, rom_len} = {4'h0, 4'd8};
    endcase
  end

  assign is_rest   = (rom_note == REST);
  assign tick      = (state_q == S_PLAY) && bus.play && (div_q == DIV_LAST);
  assign entry_end = tick && (rem_q == 4'd1);
  assign is_last   = (pos_q == POS_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (bus.restart) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (bus.play) state_d = S_LOAD;
        S_LOAD:  state_d = S_PLAY;
        S_PLAY:  if (entry_end) state_d = (is_last && !bus.loop_en) ? S_DONE : S_LOAD;
        default: state_d = S_DONE;
      endcase
    end
  end

  always_comb begin
    div_d    = div_q;
    rem_d    = rem_q;
    pos_d    = pos_q;
    note_d   = note_q;
    gate_d   = gate_q;
    strobe_d = 1'b0;
    done_d   = done_q;
    if (bus.restart) begin
      div_d  = '0;
      pos_d  = 4'd0;
      done_d = 1'b0;
      gate_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: gate_d = 1'b0;
        S_LOAD: begin
          div_d    = '0;
          rem_d    = rom_len;
          strobe_d = 1'b1;
          gate_d   = !is_rest;
          if (!is_rest) note_d = rom_note;
        end
        S_PLAY: begin
          if (bus.play) begin
            div_d = tick ? '0 : div_q + DIV_W'(1);
            if (tick) rem_d = rem_q - 4'd1;
            // Drop the gate through the last tick so repeated notes re-articulate.
            gate_d = !is_rest && !((rem_q == 4'd1) && (rom_len >= 4'd2));
          end else begin
            gate_d = 1'b0;
          end
          if (entry_end) begin
            gate_d = 1'b0;
            if (!is_last)         pos_d  = pos_q + 4'd1;
            else if (bus.loop_en) pos_d  = 4'd0;
            else                  done_d = 1'b1;
          end
        end
        default: gate_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q    <= '0;
      rem_q    <= 4'd0;
      pos_q    <= 4'd0;
      note_q   <= 4'd0;
      gate_q   <= 1'b0;
      strobe_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      div_q    <= div_d;
      rem_q    <= rem_d;
      pos_q    <= pos_d;
      note_q   <= note_d;
      gate_q   <= gate_d;
      strobe_q <= strobe_d;
      done_q   <= done_d;
    end
  end

  assign bus.note_select = note_q;
  assign bus.note_gate   = gate_q;
  assign bus.step_strobe = strobe_q;
  assign bus.song_pos    = pos_q;
  assign bus.done        = done_q;
endmodule

// File: tb/tb_note_sequence_player.sv
// Bench for note_sequence_player at TICK_DIV=4: directed scenarios plus a
// randomized run checked against an elapsed-cycle model of the song.
module tb_note_sequence_player;
  localparam int T = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  note_sequence_player_if bus ();

  note_sequence_player #(.TICK_DIV(T)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  int rom_note [16] = '{0, 1, 2, 3, 15, 3, 4, 5, 6, 7, 8, 15, 8, 6, 3, 0};
  int rom_len  [16] = '{2, 2, 2, 4, 2, 2, 2, 4, 2, 2, 4, 4, 2, 2, 2, 8};

  typedef enum {M_IDLE, M_LOAD, M_PLAY, M_DONE} mphase_t;
  mphase_t m_phase = M_IDLE;
  int      m_pos   = 0;
  int      m_el    = 0;
  int      m_note  = 0;
  bit      m_gate  = 1'b0;
  bit      m_strobe = 1'b0;
  bit      m_done  = 1'b0;

  task automatic model_reset();
    m_phase = M_IDLE; m_pos = 0; m_el = 0; m_note = 0;
    m_gate = 1'b0; m_strobe = 1'b0; m_done = 1'b0;
  endtask

  // m_el counts unpaused PLAY cycles since the entry appeared; an entry lasts len*T of them.
  task automatic model_step();
    int len;
    bit rest;
    len  = rom_len[m_pos];
    rest = (rom_note[m_pos] == 15);
    m_strobe = 1'b0;
    if (bus.restart) begin
      m_phase = M_IDLE; m_pos = 0; m_done = 1'b0; m_gate = 1'b0;
    end else begin
      case (m_phase)
        M_IDLE: begin
          m_gate = 1'b0;
          if (bus.play) m_phase = M_LOAD;
        end
        M_LOAD: begin
          m_strobe = 1'b1;
          m_el     = 0;
          m_gate   = !rest;
          if (!rest) m_note = rom_note[m_pos];
          m_phase  = M_PLAY;
        end
        M_PLAY: begin
          if (!bus.play) begin
            m_gate = 1'b0;
          end else begin
            m_el++;
            m_gate = !rest && (m_el <= (len - 1) * T);
            if (m_el == len * T) begin
              m_gate = 1'b0;
              if (m_pos < 15) begin m_pos++; m_phase = M_LOAD; end
              else if (bus.loop_en) begin m_pos = 0; m_phase = M_LOAD; end
              else begin m_done = 1'b1; m_phase = M_DONE; end
            end
          end
        end
        default: m_gate = 1'b0;
      endcase
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (!reset) model_step();
    @(negedge clk);
  endtask

  function automatic logic [10:0] dut_vec();
    return {bus.note_select, bus.note_gate, bus.step_strobe, bus.song_pos, bus.done};
  endfunction

  function automatic logic [10:0] mdl_vec();
    return {4'(m_note), m_gate, m_strobe, 4'(m_pos), m_done};
  endfunction

  task automatic test_reset();
    bus.play = 1'b0; bus.restart = 1'b0; bus.loop_en = 1'b0;
    @(negedge clk);
    n_tests++;
    if (dut_vec() !== 11'd0) begin n_fail++; $display("FAIL reset_init: got %h want 000", dut_vec()); end
    model_reset();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_tests++;
      if (dut_vec() !== 11'd0) begin n_fail++; $display("FAIL idle_hold: got %h want 000", dut_vec()); end
    end
    bus.play = 1'b1;
    for (int i = 0; i < 12; i++) step();
    n_tests++;
    if (dut_vec() !== mdl_vec()) begin n_fail++; $display("FAIL pre_reset_play: got %h want %h", dut_vec(), mdl_vec()); end
    reset = 1'b1;
    #1;
    n_tests++;
    if (dut_vec() !== 11'd0) begin n_fail++; $display("FAIL async_reset: got %h want 000", dut_vec()); end
    model_reset();
    bus.play = 1'b0;
    step();
    step();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_tests++;
      if (dut_vec() !== 11'd0) begin n_fail++; $display("FAIL idle_after_reset: got %h want 000", dut_vec()); end
    end
  endtask

  task automatic test_first_strobe();
    int s1, s2;
    bit g [0:20];
    s1 = -1; s2 = -1;
    bus.play = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      step();
      g[i] = bus.note_gate;
      n_tests++;
      if (dut_vec() !== mdl_vec()) begin n_fail++; $display("FAIL first_model: cyc %0d got %h want %h", i, dut_vec(), mdl_vec()); end
      if (bus.step_strobe === 1'b1) begin
        if (s1 < 0) begin
          s1 = i;
          n_tests++;
          if ({bus.note_select, bus.note_gate, bus.song_pos} !== {4'd0, 1'b1, 4'd0}) begin
            n_fail++; $display("FAIL first_vals: note %0d gate %0d pos %0d want 0 1 0", bus.note_select, bus.note_gate, bus.song_pos);
          end
        end else if (s2 < 0) begin
          s2 = i;
          n_tests++;
          if ({bus.note_select, bus.song_pos} !== {4'd1, 4'd1}) begin
            n_fail++; $display("FAIL second_note: note %0d pos %0d want 1 1", bus.note_select, bus.song_pos);
          end
        end
      end
    end
    n_tests++;
    if (s1 != 2) begin n_fail++; $display("FAIL first_latency: got %0d want 2", s1); end
    n_tests++;
    if (s2 - s1 != 9) begin n_fail++; $display("FAIL strobe_spacing: got %0d want 9", s2 - s1); end
    if (s2 >= 6) begin
      for (int k = 1; k <= 4; k++) begin
        n_tests++;
        if (g[s2-k] !== 1'b0) begin n_fail++; $display("FAIL articulation: gate %0d at strobe-%0d want 0", g[s2-k], k); end
      end
      n_tests++;
      if (g[s2-5] !== 1'b1) begin n_fail++; $display("FAIL gate_before_cut: gate %0d at strobe-5 want 1", g[s2-5]); end
    end
  endtask

  task automatic test_rest_and_pause();
    int  n;
    bit  found;
    bus.play = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      step();
      if (bus.step_strobe === 1'b1 && bus.song_pos === 4'd3) found = 1'b1;
    end
    n_tests++;
    if (!found) begin n_fail++; $display("FAIL reach_entry3: got no strobe want pos 3"); end
    for (int i = 0; i < 5; i++) step();
    n = 5;
    bus.play = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      n++;
      n_tests++;
      if ({bus.note_select, bus.note_gate, bus.song_pos, bus.step_strobe} !== {4'd3, 1'b0, 4'd3, 1'b0}) begin
        n_fail++; $display("FAIL pause_hold: note %0d gate %0d pos %0d want 3 0 3", bus.note_select, bus.note_gate, bus.song_pos);
      end
    end
    bus.play = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      step();
      n++;
      if (bus.step_strobe === 1'b1) found = 1'b1;
    end
    n_tests++;
    if (n != 27) begin n_fail++; $display("FAIL pause_spacing: got %0d want 27", n); end
    n_tests++;
    if ({bus.note_select, bus.note_gate, bus.song_pos} !== {4'd3, 1'b0, 4'd4}) begin
      n_fail++; $display("FAIL rest_entry: note %0d gate %0d pos %0d want 3 0 4", bus.note_select, bus.note_gate, bus.song_pos);
    end
    for (int i = 1; i <= 9; i++) begin
      step();
      n_tests++;
      if ({bus.note_select, bus.note_gate, bus.step_strobe} !== {4'd3, i == 9, i == 9}) begin
        n_fail++; $display("FAIL rest_gate: cyc %0d note %0d gate %0d strobe %0d", i, bus.note_select, bus.note_gate, bus.step_strobe);
      end
    end
    n_tests++;
    if (bus.song_pos !== 4'd5) begin n_fail++; $display("FAIL after_rest: pos %0d want 5", bus.song_pos); end
  endtask

  task automatic test_done_and_loop();
    int n;
    bit found;
    bus.play = 1'b1; bus.loop_en = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      step();
      if (bus.step_strobe === 1'b1 && bus.song_pos === 4'd15) found = 1'b1;
    end
    n_tests++;
    if (!found) begin n_fail++; $display("FAIL reach_entry15: got no strobe want pos 15"); end
    n = 0; found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      step();
      n++;
      if (bus.done === 1'b1) found = 1'b1;
    end
    n_tests++;
    if (n != 32) begin n_fail++; $display("FAIL done_latency: got %0d want 32", n); end
    for (int i = 0; i < 20; i++) begin
      step();
      n_tests++;
      if ({bus.done, bus.note_gate, bus.step_strobe} !== 3'b100) begin
        n_fail++; $display("FAIL done_hold: done %0d gate %0d strobe %0d want 1 0 0", bus.done, bus.note_gate, bus.step_strobe);
      end
    end
    bus.restart = 1'b1;
    step();
    bus.restart = 1'b0;
    n_tests++;
    if ({bus.done, bus.note_gate, bus.step_strobe, bus.song_pos} !== {3'b000, 4'd0}) begin
      n_fail++; $display("FAIL restart_clears_done: done %0d gate %0d pos %0d want 0 0 0", bus.done, bus.note_gate, bus.song_pos);
    end
    step();
    step();
    n_tests++;
    if (dut_vec() !== {4'd0, 1'b1, 1'b1, 4'd0, 1'b0}) begin
      n_fail++; $display("FAIL restart_from_done: got %h want %h", dut_vec(), {4'd0, 1'b1, 1'b1, 4'd0, 1'b0});
    end
    bus.loop_en = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      step();
      if (bus.step_strobe === 1'b1 && bus.song_pos === 4'd15) found = 1'b1;
    end
    n = 0; found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      step();
      n++;
      if (bus.step_strobe === 1'b1) found = 1'b1;
    end
    n_tests++;
    if (n != 33) begin n_fail++; $display("FAIL loop_spacing: got %0d want 33", n); end
    n_tests++;
    if ({bus.note_select, bus.note_gate, bus.song_pos, bus.done} !== {4'd0, 1'b1, 4'd0, 1'b0}) begin
      n_fail++; $display("FAIL loop_wrap: note %0d gate %0d pos %0d done %0d want 0 1 0 0", bus.note_select, bus.note_gate, bus.song_pos, bus.done);
    end
  endtask

  task automatic test_restart();
    bit found;
    bus.play = 1'b1; bus.loop_en = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      step();
      if (bus.step_strobe === 1'b1 && bus.song_pos === 4'd7) found = 1'b1;
    end
    n_tests++;
    if (!found) begin n_fail++; $display("FAIL reach_entry7: got no strobe want pos 7"); end
    for (int i = 0; i < 3; i++) step();
    bus.restart = 1'b1;
    step();
    bus.restart = 1'b0;
    n_tests++;
    if ({bus.note_gate, bus.step_strobe, bus.song_pos, bus.note_select} !== {1'b0, 1'b0, 4'd0, 4'd5}) begin
      n_fail++; $display("FAIL restart_mid: gate %0d pos %0d note %0d want 0 0 5", bus.note_gate, bus.song_pos, bus.note_select);
    end
    step();
    n_tests++;
    if (bus.step_strobe !== 1'b0) begin n_fail++; $display("FAIL restart_gap: strobe %0d want 0", bus.step_strobe); end
    step();
    n_tests++;
    if ({bus.note_select, bus.note_gate, bus.step_strobe, bus.song_pos} !== {4'd0, 1'b1, 1'b1, 4'd0}) begin
      n_fail++; $display("FAIL restart_strobe: note %0d gate %0d strobe %0d pos %0d want 0 1 1 0",
                         bus.note_select, bus.note_gate, bus.step_strobe, bus.song_pos);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 2500; i++) begin
      bus.play    = ($urandom_range(0, 9) != 0);
      bus.restart = ($urandom_range(0, 249) == 0);
      bus.loop_en = $urandom_range(0, 1) != 0;
      step();
      n_tests++;
      if (dut_vec() !== mdl_vec()) begin
        n_fail++; $display("FAIL random_model: cyc %0d got %h want %h", i, dut_vec(), mdl_vec());
      end
    end
    bus.restart = 1'b0;
  endtask

  initial begin
    test_reset();
    test_first_strobe();
    test_rest_and_pause();
    test_done_and_loop();
    test_restart();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
